// File: rtl/logic_axi4_lite_register_file.sv
// AXI4-Lite slave register bank with independent write/read engines and per-register write pulses.
// Optional LOGIC_AXI4_LITE_REGISTER_FILE_PROT_CHECK_EN rejects unprivileged accesses with SLVERR.
module logic_axi4_lite_register_file #(
  parameter int unsigned TARGET        = 0,
  parameter int unsigned DATA_BYTES    = 4,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned REGISTERS     = 16
) (
  input  logic                              i_aclk,
  input  logic                              i_areset,
  input  logic                              i_awvalid,
  output logic                              o_awready,
  input  logic [ADDRESS_WIDTH-1:0]          i_awaddr,
  input  logic [2:0]                        i_awprot,
  input  logic                              i_wvalid,
  output logic                              o_wready,
  input  logic [8*DATA_BYTES-1:0]           i_wdata,
  input  logic [DATA_BYTES-1:0]             i_wstrb,
  output logic                              o_bvalid,
  input  logic                              i_bready,
  output logic [1:0]                        o_bresp,
  input  logic                              i_arvalid,
  output logic                              o_arready,
  input  logic [ADDRESS_WIDTH-1:0]          i_araddr,
  input  logic [2:0]                        i_arprot,
  output logic                              o_rvalid,
  input  logic                              i_rready,
  output logic [8*DATA_BYTES-1:0]           o_rdata,
  output logic [1:0]                        o_rresp,
  output logic [REGISTERS*8*DATA_BYTES-1:0] o_registers,
  output logic [REGISTERS-1:0]              o_registers_written
);

  localparam int unsigned W    = 8 * DATA_BYTES;
  localparam int unsigned OFFS = $clog2(DATA_BYTES);
  localparam int unsigned IW   = ADDRESS_WIDTH - OFFS;

  logic                  r_aw_held;
  logic [IW-1:0]         r_aw_idx;
  logic [2:0]            r_aw_prot;
  logic                  r_w_held;
  logic [W-1:0]          r_wdata;
  logic [DATA_BYTES-1:0] r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [W-1:0]          r_rdata;
  logic [1:0]            r_rresp;
  logic [W-1:0]          r_regs [REGISTERS];
  logic [REGISTERS-1:0]  r_written;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic [IW-1:0]         w_aw_idx;
  logic [2:0]            w_aw_prot;
  logic [W-1:0]          w_wdata;
  logic [DATA_BYTES-1:0] w_wstrb;
  logic                  w_commit;
  logic                  w_aw_ok;
  logic [IW-1:0]         w_ar_idx;
  logic                  w_ar_ok;
  logic                  w_unused;

  // Readies are forced low while reset is asserted, high again as soon as it releases.
  assign o_awready = ~i_areset & ~r_aw_held & ~r_bvalid;
  assign o_wready  = ~i_areset & ~r_w_held & ~r_bvalid;
  assign o_arready = ~i_areset & ~r_rvalid;

  assign w_aw_hs = i_awvalid & o_awready;
  assign w_w_hs  = i_wvalid & o_wready;
  assign w_ar_hs = i_arvalid & o_arready;

  // Commit uses the held side or the side completing this edge.
  assign w_aw_idx  = r_aw_held ? r_aw_idx : i_awaddr[ADDRESS_WIDTH-1:OFFS];
  assign w_aw_prot = r_aw_held ? r_aw_prot : i_awprot;
  assign w_wdata   = r_w_held ? r_wdata : i_wdata;
  assign w_wstrb   = r_w_held ? r_wstrb : i_wstrb;
  assign w_commit  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
  assign w_ar_idx  = i_araddr[ADDRESS_WIDTH-1:OFFS];

`ifdef LOGIC_AXI4_LITE_REGISTER_FILE_PROT_CHECK_EN
  assign w_aw_ok = (32'(w_aw_idx) < REGISTERS) & w_aw_prot[0];
  assign w_ar_ok = (32'(w_ar_idx) < REGISTERS) & i_arprot[0];
`else
  assign w_aw_ok = 32'(w_aw_idx) < REGISTERS;
  assign w_ar_ok = 32'(w_ar_idx) < REGISTERS;
`endif

  assign w_unused = ^{i_awprot, i_arprot, i_awaddr, i_araddr, w_aw_prot, TARGET[0]};

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
      r_aw_prot <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_aw_ok ? 2'b00 : 2'b10;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_idx  <= i_awaddr[ADDRESS_WIDTH-1:OFFS];
          r_aw_prot <= i_awprot;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= i_wdata;
          r_wstrb  <= i_wstrb;
        end
        if (r_bvalid && i_bready) begin
          r_bvalid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      for (int i = 0; i < REGISTERS; i++) begin
        r_regs[i] <= '0;
      end
      r_written <= '0;
    end else begin
      r_written <= '0;
      if (w_commit && w_aw_ok) begin
        r_written[w_aw_idx] <= 1'b1;
        for (int b = 0; b < DATA_BYTES; b++) begin
          if (w_wstrb[b]) begin
            r_regs[w_aw_idx][8*b +: 8] <= w_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Nonblocking array update means a read on the commit edge sees the old word.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ar_ok ? r_regs[w_ar_idx] : '0;
      r_rresp  <= w_ar_ok ? 2'b00 : 2'b10;
    end else if (r_rvalid && i_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  for (genvar i = 0; i < REGISTERS; i++) begin : g_flat
    assign o_registers[i*W +: W] = r_regs[i];
  end

  assign o_registers_written = r_written;
  assign o_bvalid            = r_bvalid;
  assign o_bresp             = r_bresp;
  assign o_rvalid            = r_rvalid;
  assign o_rdata             = r_rdata;
  assign o_rresp             = r_rresp;

endmodule

// File: tb/tb_logic_axi4_lite_register_file.sv
// Directed plus randomized bench for logic_axi4_lite_register_file against an array-based model.
module tb_logic_axi4_lite_register_file;
  localparam int DB = 4;
  localparam int AW = 8;
  localparam int NR = 16;
  localparam int W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [AW-1:0]     awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic [W-1:0]      wdata, rdata;
  logic [DB-1:0]     wstrb;
  logic [1:0]        bresp, rresp;
  logic [NR*W-1:0]   registers;
  logic [NR-1:0]     registers_written;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] m_regs [NR];

  always #5 clk = ~clk;

  logic_axi4_lite_register_file #(
    .TARGET(0), .DATA_BYTES(DB), .ADDRESS_WIDTH(AW), .REGISTERS(NR)
  ) dut (
    .i_aclk(clk), .i_areset(rst),
    .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr), .i_awprot(awprot),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
    .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr), .i_arprot(arprot),
    .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata), .o_rresp(rresp),
    .o_registers(registers), .o_registers_written(registers_written)
  );

  task automatic chk(input string tag, input logic [NR*W-1:0] obs, input logic [NR*W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*W-1:0] model_flat();
    logic [NR*W-1:0] r;
    for (int i = 0; i < NR; i++) r[i*W +: W] = m_regs[i];
    return r;
  endfunction

  function automatic bit prot_ok(input logic [2:0] p);
`ifdef LOGIC_AXI4_LITE_REGISTER_FILE_PROT_CHECK_EN
    return p[0];
`else
    return 1'b1;
`endif
  endfunction

  // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
  task automatic write_txn(input logic [AW-1:0] addr, input logic [W-1:0] data,
                           input logic [DB-1:0] strb, input logic [2:0] prot,
                           input int lead, input int bwait);
    int idx, aw_start, w_start, c;
    bit aw_done, w_done, a_hs, w_hs, ok;
    logic [1:0] eresp;
    logic [NR-1:0] ewr;
    idx = int'(addr) / DB;
    ok = (idx < NR) && prot_ok(prot);
    aw_start = lead > 0 ? lead : 0;
    w_start = lead < 0 ? -lead : 0;
    c = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && c < 20) begin
      @(negedge clk);
      if (!aw_done && c >= aw_start) begin awvalid = 1; awaddr = addr; awprot = prot; end
      if (!w_done && c >= w_start) begin wvalid = 1; wdata = data; wstrb = strb; end
      chk("pre_commit_bvalid", bvalid, 1'b0);
      chk("pre_commit_registers", registers, model_flat());
      #1;
      a_hs = awvalid && awready;
      w_hs = wvalid && wready;
      @(posedge clk); #1;
      if (a_hs) begin aw_done = 1; awvalid = 0; end
      if (w_hs) begin w_done = 1; wvalid = 0; end
      c++;
    end
    chk("write_handshake_done", aw_done && w_done, 1'b1);
    ewr = '0;
    if (ok) begin
      ewr[idx] = 1'b1;
      for (int b = 0; b < DB; b++) if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
    end
    eresp = ok ? 2'b00 : 2'b10;
    chk("commit_bvalid", bvalid, 1'b1);
    chk("commit_bresp", bresp, eresp);
    chk("commit_written", registers_written, ewr);
    chk("commit_registers", registers, model_flat());
    chk("commit_awready_low", awready, 1'b0);
    chk("commit_wready_low", wready, 1'b0);
    for (int k = 0; k < bwait; k++) begin
      @(posedge clk); #1;
      chk("bwait_bvalid", bvalid, 1'b1);
      chk("bwait_bresp", bresp, eresp);
      chk("bwait_written", registers_written, {NR{1'b0}});
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    chk("b_done_bvalid", bvalid, 1'b0);
    chk("b_done_written", registers_written, {NR{1'b0}});
    chk("b_done_awready", awready, 1'b1);
  endtask

  task automatic read_txn(input logic [AW-1:0] addr, input logic [2:0] prot, input int hold);
    int idx, c;
    bit ok;
    logic [W-1:0] edata;
    logic [1:0] eresp;
    idx = int'(addr) / DB;
    ok = (idx < NR) && prot_ok(prot);
    @(negedge clk);
    arvalid = 1; araddr = addr; arprot = prot;
    c = 0;
    #1;
    while (!arready && c < 20) begin
      @(negedge clk); #1;
      c++;
    end
    chk("read_arready", arready, 1'b1);
    edata = ok ? m_regs[idx] : '0;
    eresp = ok ? 2'b00 : 2'b10;
    @(posedge clk); #1;
    arvalid = 0;
    chk("read_rvalid", rvalid, 1'b1);
    chk("read_rdata", rdata, edata);
    chk("read_rresp", rresp, eresp);
    chk("read_arready_low", arready, 1'b0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("rhold_rvalid", rvalid, 1'b1);
      chk("rhold_rdata", rdata, edata);
      chk("rhold_rresp", rresp, eresp);
      chk("rhold_arready", arready, 1'b0);
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chk("r_done_rvalid", rvalid, 1'b0);
    chk("r_done_arready", arready, 1'b1);
  endtask

  initial begin
    int lead;
    logic [W-1:0] old2;
    rst = 1;
    awvalid = 0; awaddr = '0; awprot = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
    arvalid = 0; araddr = '0; arprot = '0; rready = 0;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_registers", registers, model_flat());
    chk("rst_written", registers_written, {NR{1'b0}});
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("post_rst_awready", awready, 1'b1);
    chk("post_rst_wready", wready, 1'b1);
    chk("post_rst_arready", arready, 1'b1);

    // AW+W together, then W leading AW by three cycles, then held read
    write_txn(8'h04, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0);
    write_txn(8'h04, 32'h000000AA, 4'h1, 3'b001, 3, 0);
    chk("reg1_partial", registers[63:32], 32'hDEADBEAA);
    read_txn(8'h04, 3'b001, 5);

    // Out of range
    write_txn(8'h40, 32'hFFFFFFFF, 4'hF, 3'b001, 0, 1);
    read_txn(8'h40, 3'b001, 0);

    // Read accepted on the commit edge of a write to the same register
    old2 = m_regs[2];
    @(negedge clk);
    awvalid = 1; awaddr = 8'h08; awprot = 3'b001;
    wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF;
    arvalid = 1; araddr = 8'h08; arprot = 3'b001;
    #1;
    chk("same_edge_readies", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    m_regs[2] = 32'h12345678;
    chk("same_edge_rdata_old", rdata, old2);
    chk("same_edge_rvalid", rvalid, 1'b1);
    chk("same_edge_bvalid", bvalid, 1'b1);
    chk("same_edge_written", registers_written, 16'h0004);
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    chk("same_edge_done", {bvalid, rvalid}, 2'b00);
    read_txn(8'h08, 3'b001, 0);

`ifdef LOGIC_AXI4_LITE_REGISTER_FILE_PROT_CHECK_EN
    write_txn(8'h00, 32'hCAFEF00D, 4'hF, 3'b000, 0, 0);
    write_txn(8'h00, 32'hCAFEF00D, 4'hF, 3'b001, 0, 0);
    read_txn(8'h00, 3'b000, 1);
    read_txn(8'h00, 3'b001, 0);
`endif

    // Reset while an AW is held: it must not pair with a later W
    @(negedge clk);
    awvalid = 1; awaddr = 8'h0C; awprot = 3'b001;
    #1;
    chk("mid_aw_ready", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 0;
    @(negedge clk); rst = 1;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    #1;
    chk("mid_rst_registers", registers, model_flat());
    chk("mid_rst_awready", awready, 1'b0);
    @(negedge clk); rst = 0;
    write_txn(8'h10, 32'h0BADF00D, 4'hF, 3'b001, 3, 0);

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      lead = $urandom_range(0, 6);
      lead -= 3;
      if ($urandom_range(0, 1) == 1)
        write_txn(AW'($urandom_range(0, 8'h4F)), $urandom, DB'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), lead, $urandom_range(0, 2));
      else
        read_txn(AW'($urandom_range(0, 8'h4F)), 3'($urandom_range(0, 7)), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
